// File: rtl/trig_pkg.sv
// Shared definitions for the multi-channel trigger unit.
//   CFG_W        width of one channel's configuration field
//   CFG_*        bit positions inside a channel configuration field
//   trig_state_t trigger sequencer states
package trig_pkg;

    localparam int CFG_W    = 5;
    localparam int CFG_DC   = 0;  // always satisfied
    localparam int CFG_LOW  = 1;  // low level  (Lff5 == 1)
    localparam int CFG_HIGH = 2;  // high level (Hff5 == 1)
    localparam int CFG_NEG  = 3;  // Lff5 rising (signal crossed below low threshold)
    localparam int CFG_POS  = 4;  // Hff5 rising (signal crossed above high threshold)

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLDOFF = 2'd1,
        WAIT    = 2'd2,
        TRIG    = 2'd3
    } trig_state_t;

endpackage

// File: rtl/trig_chan.sv
// One trigger channel: edge detection, sticky edge latches and qualification.
// Ports:
//   clk, rst_n  clock / async active-low reset
//   inWait      sequencer is in WAIT; edges are only detected and latched there
//   cfg         this channel's 5-bit configuration
//   chH, chL    synchronised comparator outputs (above high / below low)
//   enabled     channel has any configuration bit set
//   satisfied   channel condition currently met (includes edge seen this cycle)
module trig_chan
    import trig_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inWait,
    input  logic [CFG_W-1:0] cfg,
    input  logic             chH,
    input  logic             chL,
    output logic             enabled,
    output logic             satisfied
);

    logic prevH;
    logic prevL;
    logic posLatch;
    logic negLatch;
    logic posEdge;
    logic negEdge;

    // Previous-sample flops run in every state so the first WAIT cycle sees
    // a valid history; a level that was already high before WAIT is no edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prevH <= 1'b0;
            prevL <= 1'b0;
        end else begin
            prevH <= chH;
            prevL <= chL;
        end
    end

    assign posEdge = inWait & chH & ~prevH;
    assign negEdge = inWait & chL & ~prevL;

    // Edges are remembered for the rest of WAIT so an AND combine can pair an
    // earlier edge with a later level; leaving WAIT wipes them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            posLatch <= 1'b0;
            negLatch <= 1'b0;
        end else if (!inWait) begin
            posLatch <= 1'b0;
            negLatch <= 1'b0;
        end else begin
            if (posEdge) posLatch <= 1'b1;
            if (negEdge) negLatch <= 1'b1;
        end
    end

    assign enabled   = |cfg;
    assign satisfied = enabled & ( cfg[CFG_DC]
                                 | (cfg[CFG_LOW]  & chL)
                                 | (cfg[CFG_HIGH] & chH)
                                 | (cfg[CFG_NEG]  & (negEdge | negLatch))
                                 | (cfg[CFG_POS]  & (posEdge | posLatch)) );

endmodule

// File: rtl/multi_chan_trigger.sv
// N-channel trigger unit: per-channel qualification, AND/OR combine, post-arm
// holdoff, software force and a sticky registered trigger flag.
// Ports:
//   clk, rst_n   clock / async active-low reset
//   armed        capture controller armed; low returns everything to IDLE
//   CHxHff5      per-channel above-high-threshold flags (synchronised)
//   CHxLff5      per-channel below-low-threshold flags (synchronised)
//   trig_cfg     5 config bits per channel, channel k at [5k+4:5k]
//   comb_mode    0 = AND of enabled channels, 1 = OR
//   holdoff      cycles to ignore conditions after arming
//   trig_force   software trigger (HOLDOFF or WAIT)
//   triggered    sticky trigger flag
//   trig_pulse   one-cycle strobe when triggered sets
//   trig_src     satisfied-channel snapshot at the trigger
module multi_chan_trigger
    import trig_pkg::*;
#(
    parameter int NUM_CH    = 5,
    parameter int HOLDOFF_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    armed,
    input  logic [NUM_CH-1:0]       CHxHff5,
    input  logic [NUM_CH-1:0]       CHxLff5,
    input  logic [CFG_W*NUM_CH-1:0] trig_cfg,
    input  logic                    comb_mode,
    input  logic [HOLDOFF_W-1:0]    holdoff,
    input  logic                    trig_force,
    output logic                    triggered,
    output logic                    trig_pulse,
    output logic [NUM_CH-1:0]       trig_src
);

    trig_state_t           stateReg, stateNext;
    logic [HOLDOFF_W-1:0]  counterReg, counterNext;
    logic                  triggeredReg, triggeredNext;
    logic                  pulseReg, pulseNext;
    logic [NUM_CH-1:0]     srcReg, srcNext;

    logic [NUM_CH-1:0]     enVec;
    logic [NUM_CH-1:0]     satVec;
    logic                  inWait;
    logic                  combHit;

    assign inWait = (stateReg == WAIT);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
            trig_chan u_chan (
                .clk       (clk),
                .rst_n     (rst_n),
                .inWait    (inWait),
                .cfg       (trig_cfg[gi*CFG_W +: CFG_W]),
                .chH       (CHxHff5[gi]),
                .chL       (CHxLff5[gi]),
                .enabled   (enVec[gi]),
                .satisfied (satVec[gi])
            );
        end
    endgenerate

    // AND needs at least one enabled channel, otherwise an all-disabled
    // configuration would trivially satisfy it.
    always_comb begin
        if (comb_mode) combHit = |satVec;
        else           combHit = (|enVec) & (&(satVec | ~enVec));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg     <= IDLE;
            counterReg   <= '0;
            triggeredReg <= 1'b0;
            pulseReg     <= 1'b0;
            srcReg       <= '0;
        end else begin
            stateReg     <= stateNext;
            counterReg   <= counterNext;
            triggeredReg <= triggeredNext;
            pulseReg     <= pulseNext;
            srcReg       <= srcNext;
        end
    end

    always_comb begin
        stateNext     = stateReg;
        counterNext   = counterReg;
        triggeredNext = triggeredReg;
        pulseNext     = 1'b0;
        srcNext       = srcReg;

        if (!armed) begin
            // Disarm wins over anything else happening this cycle.
            stateNext     = IDLE;
            counterNext   = '0;
            triggeredNext = 1'b0;
            srcNext       = '0;
        end else begin
            unique case (stateReg)
                IDLE: begin
                    if (holdoff == '0) begin
                        stateNext = WAIT;
                    end else begin
                        stateNext   = HOLDOFF;
                        counterNext = holdoff;
                    end
                end
                HOLDOFF: begin
                    // Channel conditions are ignored here, so a forced
                    // trigger reports no source channels.
                    if (trig_force) begin
                        stateNext     = TRIG;
                        counterNext   = '0;
                        triggeredNext = 1'b1;
                        pulseNext     = 1'b1;
                        srcNext       = '0;
                    end else if (counterReg <= HOLDOFF_W'(1)) begin
                        stateNext   = WAIT;
                        counterNext = '0;
                    end else begin
                        counterNext = counterReg - HOLDOFF_W'(1);
                    end
                end
                WAIT: begin
                    if (combHit || trig_force) begin
                        stateNext     = TRIG;
                        triggeredNext = 1'b1;
                        pulseNext     = 1'b1;
                        srcNext       = satVec;
                    end
                end
                TRIG: begin
                    stateNext = TRIG;
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    assign triggered  = triggeredReg;
    assign trig_pulse = pulseReg;
    assign trig_src   = srcReg;

endmodule

// File: tb/tb_multi_chan_trigger.sv
// Directed bench for multi_chan_trigger: a 5-channel/16-bit instance for the
// functional cases and an 8-channel/4-bit instance for holdoff and reset.
module tb_multi_chan_trigger;

    logic        clk = 1'b0;
    logic        rst_n;

    // 5-channel instance
    logic        armed;
    logic [4:0]  chH, chL;
    logic [24:0] cfg;
    logic        combMode;
    logic [15:0] holdoff;
    logic        force_;
    logic        triggered, pulse;
    logic [4:0]  src;

    // 8-channel instance
    logic        armed8;
    logic [7:0]  chH8, chL8;
    logic [39:0] cfg8;
    logic [3:0]  holdoff8;
    logic        triggered8, pulse8;
    logic [7:0]  src8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multi_chan_trigger #(.NUM_CH(5), .HOLDOFF_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .armed(armed), .CHxHff5(chH), .CHxLff5(chL),
        .trig_cfg(cfg), .comb_mode(combMode), .holdoff(holdoff), .trig_force(force_),
        .triggered(triggered), .trig_pulse(pulse), .trig_src(src)
    );

    multi_chan_trigger #(.NUM_CH(8), .HOLDOFF_W(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .armed(armed8), .CHxHff5(chH8), .CHxLff5(chL8),
        .trig_cfg(cfg8), .comb_mode(1'b0), .holdoff(holdoff8), .trig_force(1'b0),
        .triggered(triggered8), .trig_pulse(pulse8), .trig_src(src8)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic seenPulse;

        rst_n = 1'b0; armed = 0; chH = '0; chL = '0; cfg = '0; combMode = 0;
        holdoff = '0; force_ = 0;
        armed8 = 0; chH8 = '0; chL8 = '0; cfg8 = '0; holdoff8 = '0;
        step(); step();
        rst_n = 1'b1;
        chk("reset_trig", {31'd0, triggered}, 32'd0);
        chk("reset_pulse", {31'd0, pulse}, 32'd0);
        chk("reset_src", {27'd0, src}, 32'd0);

        // 1: don't-care channel, holdoff 0 -> fires on second edge after arming
        cfg[4:0] = 5'h01; armed = 1;
        step();
        chk("t1_edge1_trig", {31'd0, triggered}, 32'd0);
        step();
        chk("t1_edge2_trig", {31'd0, triggered}, 32'd1);
        chk("t1_edge2_pulse", {31'd0, pulse}, 32'd1);
        chk("t1_src", {27'd0, src}, 32'h01);
        step();
        chk("t1_pulse_drop", {31'd0, pulse}, 32'd0);
        chk("t1_sticky", {31'd0, triggered}, 32'd1);
        armed = 0; step();
        chk("t1_disarm_trig", {31'd0, triggered}, 32'd0);
        chk("t1_disarm_src", {27'd0, src}, 32'd0);

        // 2: pos edge on ch1, edge during HOLDOFF must not count
        cfg = '0; cfg[9:5] = 5'h10; holdoff = 16'd3; armed = 1;
        step();                   // IDLE -> HOLDOFF
        chH[1] = 1;
        step(); step(); step();   // third HOLDOFF edge -> WAIT
        chk("t2_enter_wait", {31'd0, triggered}, 32'd0);
        step(); step();
        chk("t2_no_stale_edge", {31'd0, triggered}, 32'd0);
        chH[1] = 0; step();
        chH[1] = 1; step();
        chk("t2_fire", {31'd0, triggered}, 32'd1);
        chk("t2_src", {27'd0, src}, 32'h02);
        armed = 0; chH = '0; step();

        // 3: AND of latched neg edge (ch0) and high level (ch2); then OR
        cfg = '0; cfg[4:0] = 5'h08; cfg[14:10] = 5'h04; holdoff = '0; armed = 1;
        step();                   // -> WAIT
        chL[0] = 1; step();
        chL[0] = 0;
        chk("t3_and_half", {31'd0, triggered}, 32'd0);
        repeat (4) step();
        chk("t3_and_wait", {31'd0, triggered}, 32'd0);
        chH[2] = 1; step();
        chk("t3_and_fire", {31'd0, triggered}, 32'd1);
        chk("t3_and_src", {27'd0, src}, 32'h05);
        armed = 0; chH = '0; step();
        combMode = 1; armed = 1;
        step(); step();
        chk("t3_or_idle", {31'd0, triggered}, 32'd0);
        chL[0] = 1; step();
        chL[0] = 0;
        chk("t3_or_fire", {31'd0, triggered}, 32'd1);
        chk("t3_or_src", {27'd0, src}, 32'h01);
        armed = 0; combMode = 0; step();

        // 4: no enabled channels never fires; force still does
        cfg = '0; armed = 1; step();
        seenPulse = 0;
        for (int i = 0; i < 100; i++) begin
            chH = 5'(i); chL = 5'(~i);
            step();
            seenPulse = seenPulse | pulse | triggered;
        end
        chk("t4_no_fire_100", {31'd0, seenPulse}, 32'd0);
        chH = '0; chL = '0;
        force_ = 1; step(); force_ = 0;
        chk("t4_force_trig", {31'd0, triggered}, 32'd1);
        chk("t4_force_src", {27'd0, src}, 32'd0);

        // 5: disarm clears; stale edge latch must not survive re-arm
        armed = 0; step();
        chk("t5_disarm", {31'd0, triggered}, 32'd0);
        cfg[4:0] = 5'h08; cfg[14:10] = 5'h04; armed = 1;
        step();
        chL[0] = 1; step(); chL[0] = 0;   // latch ch0 neg edge
        armed = 0; step();
        armed = 1; step();                // back in WAIT, latch must be clear
        chH[2] = 1; step(); step();
        chk("t5_no_stale", {31'd0, triggered}, 32'd0);
        armed = 0; chH = '0; cfg = '0; step();

        // force during HOLDOFF aborts holdoff
        holdoff = 16'd10; armed = 1; step(); step();
        force_ = 1; step(); force_ = 0;
        chk("t5_hold_force", {31'd0, triggered}, 32'd1);
        chk("t5_hold_pulse", {31'd0, pulse}, 32'd1);
        armed = 0; step();

        // 6: 8 channels, 4-bit holdoff of 15
        cfg8[4:0] = 5'h01; holdoff8 = 4'd15; armed8 = 1;
        step();                           // -> HOLDOFF
        seenPulse = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            seenPulse = seenPulse | triggered8;
        end
        chk("t6_holdoff_quiet", {31'd0, seenPulse}, 32'd0);
        step();
        chk("t6_fire_after_15", {31'd0, triggered8}, 32'd1);
        chk("t6_src", {24'd0, src8}, 32'h01);
        #2 rst_n = 0; #1;
        chk("t6_async_trig", {31'd0, triggered8}, 32'd0);
        chk("t6_async_src", {24'd0, src8}, 32'd0);
        step();
        rst_n = 1;
        step();                           // -> HOLDOFF
        step(); step(); step();
        #2 rst_n = 0; #1;                 // mid-HOLDOFF reset
        step();
        rst_n = 1;
        step();                           // fresh IDLE -> HOLDOFF
        seenPulse = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            seenPulse = seenPulse | triggered8;
        end
        chk("t6_full_recount", {31'd0, seenPulse}, 32'd0);
        step();
        chk("t6_refire", {31'd0, triggered8}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
